// File: rtl/tx_hp_pkg.sv
// Shared types and constants for the TX huge-page scheduler.
package tx_hp_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        RELEASE
    } state_e;

    // PCIe read requests must not cross this byte boundary.
    localparam int PCIE_BOUNDARY_BYTES = 4096;

    // Shift converting qwords to bytes.
    localparam int QW_SHIFT = 3;

endpackage

// File: rtl/tx_hp_chunk_len.sv
// Combinational chunk length: the smallest of the qwords left in the page,
// the maximum chunk size, and the qwords left before the next 4 KB boundary.
module tx_hp_chunk_len
    import tx_hp_pkg::*;
#(
    parameter int MAX_CHUNK_QW = 64,
    parameter int LEN_W        = $clog2(MAX_CHUNK_QW) + 1
) (
    input  logic [31:0]      remaining_i,
    input  logic [8:0]       addrQw_i,
    output logic [LEN_W-1:0] len_o
);

    localparam logic [31:0] MAX_C = 32'(MAX_CHUNK_QW);

    logic [9:0]  boundaryQw;
    logic [31:0] limit;

    // Narrow the limit step by step; the result never exceeds MAX_CHUNK_QW so it fits LEN_W.
    always_comb begin
        boundaryQw = 10'(PCIE_BOUNDARY_BYTES >> QW_SHIFT) - {1'b0, addrQw_i};
        limit      = MAX_C;
        if ({22'd0, boundaryQw} < limit) begin
            limit = {22'd0, boundaryQw};
        end
        if (remaining_i < limit) begin
            limit = remaining_i;
        end
        len_o = LEN_W'(limit);
    end

endmodule

// File: rtl/tx_huge_page_sched.sv
// TX huge-page scheduler: serves the two host huge pages in ping-pong order,
// splits each into boundary-safe PCIe read chunks, tracks outstanding chunks
// and hands the page back to the host once all of its chunks have completed.
// Optional statistics counters are enabled with TX_HP_SCHED_STATS_EN.
module tx_huge_page_sched
    import tx_hp_pkg::*;
#(
    parameter int MAX_CHUNK_QW    = 64,
    parameter int MAX_OUTSTANDING = 4,
    localparam int LEN_W          = $clog2(MAX_CHUNK_QW) + 1
) (
    input  logic             trn_clk,
    input  logic             reset_n,
    input  logic             huge_page_to_hw_1,
    input  logic             huge_page_to_hw_2,
    input  logic [63:0]      huge_page_addr_1,
    input  logic [63:0]      huge_page_addr_2,
    input  logic [31:0]      huge_page_qwords_1,
    input  logic [31:0]      huge_page_qwords_2,
    output logic             huge_page_to_host_1,
    output logic             huge_page_to_host_2,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [63:0]      req_addr,
    output logic [LEN_W-1:0] req_len_qw,
    input  logic             chunk_done,
`ifdef TX_HP_SCHED_STATS_EN
    output logic [31:0]      stat_pages,
    output logic [31:0]      stat_qwords,
`endif
    output logic             protocol_err
);

    localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUTSTANDING);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [63:0]      curAddr_q, curAddr_d;
    logic [31:0]      remaining_q, remaining_d;
    logic [3:0]       outstanding_q, outstanding_d;
    logic             protocolErr_q, protocolErr_d;

    logic [LEN_W-1:0] chunkLen;
    logic             reqValid;
    logic             accept;
    logic             doneValid;
    logic             selHw;
    logic [63:0]      selAddr;
    logic [31:0]      selQwords;

    // Mux the inputs of the currently selected page (sel_q = 0 is page 1).
    always_comb begin
        selHw     = sel_q ? huge_page_to_hw_2  : huge_page_to_hw_1;
        selAddr   = sel_q ? huge_page_addr_2   : huge_page_addr_1;
        selQwords = sel_q ? huge_page_qwords_2 : huge_page_qwords_1;
    end

    tx_hp_chunk_len #(
        .MAX_CHUNK_QW (MAX_CHUNK_QW),
        .LEN_W        (LEN_W)
    ) u_chunk_len (
        .remaining_i (remaining_q),
        .addrQw_i    (curAddr_q[11:3]),
        .len_o       (chunkLen)
    );

    assign reqValid = (state_q == ISSUE) && (outstanding_q < MAX_OUT_C);
    assign accept   = reqValid && req_ready;

    // Next-state logic: page load, chunk issue, drain and release.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        curAddr_d   = curAddr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (selHw) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                curAddr_d   = selAddr & ~64'd7;
                remaining_d = selQwords;
                state_d     = (selQwords == 32'd0) ? RELEASE : ISSUE;
            end
            ISSUE: begin
                if (accept) begin
                    curAddr_d   = curAddr_q + (64'(chunkLen) << QW_SHIFT);
                    remaining_d = remaining_q - 32'(chunkLen);
                    if (remaining_d == 32'd0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (outstanding_q == 4'd0) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                sel_d   = ~sel_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outstanding-chunk credit tracking; a completion with nothing in flight is flagged and dropped.
    always_comb begin
        doneValid     = chunk_done && (outstanding_q != 4'd0);
        protocolErr_d = protocolErr_q || (chunk_done && (outstanding_q == 4'd0));
        outstanding_d = outstanding_q;
        if (accept && !doneValid) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && doneValid) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Scheduler state registers.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sel_q         <= 1'b0;
            curAddr_q     <= 64'd0;
            remaining_q   <= 32'd0;
            outstanding_q <= 4'd0;
            protocolErr_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            curAddr_q     <= curAddr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            protocolErr_q <= protocolErr_d;
        end
    end

`ifdef TX_HP_SCHED_STATS_EN
    logic [31:0] statPages_q;
    logic [31:0] statQwords_q;

    // Wrapping counters of released pages and of qwords requested.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            statPages_q  <= 32'd0;
            statQwords_q <= 32'd0;
        end else begin
            if (state_q == RELEASE) begin
                statPages_q <= statPages_q + 32'd1;
            end
            if (accept) begin
                statQwords_q <= statQwords_q + 32'(chunkLen);
            end
        end
    end

    assign stat_pages  = statPages_q;
    assign stat_qwords = statQwords_q;
`endif

    assign req_valid           = reqValid;
    assign req_addr            = curAddr_q;
    assign req_len_qw          = chunkLen;
    assign huge_page_to_host_1 = (state_q == RELEASE) && !sel_q;
    assign huge_page_to_host_2 = (state_q == RELEASE) && sel_q;
    assign protocol_err        = protocolErr_q;

endmodule

// File: tb/tb_tx_huge_page_sched.sv
// Self-checking bench for tx_huge_page_sched: a reference chunking model fills
// a scoreboard of expected requests and page returns, which a monitor drains
// as the DUT accepts requests and pulses pages back to the host.
module tb_tx_huge_page_sched;

    localparam int MAX_CHUNK = 64;
    localparam int MAX_OUT   = 2;
    localparam int LEN_W     = $clog2(MAX_CHUNK) + 1;

    typedef struct {
        logic [63:0] addr;
        int          len;
    } chunk_t;

    logic             trn_clk = 1'b0;
    logic             reset_n;
    logic             hw1, hw2;
    logic [63:0]      addr1, addr2;
    logic [31:0]      qw1, qw2;
    logic             host1, host2;
    logic             req_valid, req_ready;
    logic [63:0]      req_addr;
    logic [LEN_W-1:0] req_len_qw;
    logic             chunk_done;
    logic             protocol_err;
`ifdef TX_HP_SCHED_STATS_EN
    logic [31:0]      stat_pages, stat_qwords;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acceptCount = 0;
    int hostCnt1    = 0;
    int hostCnt2    = 0;
    int hostCyc1    = 0;
    int hostCyc2    = 0;
    int doneCyc     = 0;

    chunk_t expQ[$];
    int     expPageQ[$];

    tx_huge_page_sched #(
        .MAX_CHUNK_QW    (MAX_CHUNK),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .trn_clk             (trn_clk),
        .reset_n             (reset_n),
        .huge_page_to_hw_1   (hw1),
        .huge_page_to_hw_2   (hw2),
        .huge_page_addr_1    (addr1),
        .huge_page_addr_2    (addr2),
        .huge_page_qwords_1  (qw1),
        .huge_page_qwords_2  (qw2),
        .huge_page_to_host_1 (host1),
        .huge_page_to_host_2 (host2),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_addr            (req_addr),
        .req_len_qw          (req_len_qw),
        .chunk_done          (chunk_done),
`ifdef TX_HP_SCHED_STATS_EN
        .stat_pages          (stat_pages),
        .stat_qwords         (stat_qwords),
`endif
        .protocol_err        (protocol_err)
    );

    // Free-running clock and cycle counter.
    always #5 trn_clk = ~trn_clk;
    always @(posedge trn_clk) cyc <= cyc + 1;

    // Hard stop if the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference chunking: split a page into requests bounded by size and 4 KB boundaries.
    task automatic modelPage(input logic [63:0] addr, input logic [31:0] qw);
        logic [63:0] a;
        int          rem;
        int          toBoundary;
        int          l;
        chunk_t      c;
        a   = addr & ~64'd7;
        rem = int'(qw);
        while (rem > 0) begin
            toBoundary = (4096 - int'(a[11:0])) / 8;
            l = rem;
            if (l > MAX_CHUNK) l = MAX_CHUNK;
            if (l > toBoundary) l = toBoundary;
            c.addr = a;
            c.len  = l;
            expQ.push_back(c);
            a   = a + 64'(l * 8);
            rem = rem - l;
        end
    endtask

    task automatic applyStimulus(input int page, input logic [63:0] addr, input logic [31:0] qw);
        @(posedge trn_clk);
        #1;
        if (page == 1) begin
            addr1 = addr;
            qw1   = qw;
            hw1   = 1'b1;
        end else begin
            addr2 = addr;
            qw2   = qw;
            hw2   = 1'b1;
        end
        modelPage(addr, qw);
        expPageQ.push_back(page);
    endtask

    task automatic pulseDone();
        @(posedge trn_clk);
        #1;
        chunk_done = 1'b1;
        doneCyc    = cyc;
        @(posedge trn_clk);
        #1;
        chunk_done = 1'b0;
    endtask

    task automatic waitAccepts(input int target, input string tag);
        int n;
        n = 0;
        while (acceptCount < target && n < 200) begin
            @(negedge trn_clk);
            #2;
            n++;
        end
        checkOutput(tag, 64'(acceptCount), 64'(target));
    endtask

    task automatic waitHost(input int page, input int target);
        int n;
        n = 0;
        while (((page == 1) ? hostCnt1 : hostCnt2) < target && n < 200) begin
            @(negedge trn_clk);
            #2;
            n++;
        end
        checkOutput((page == 1) ? "host1 return count" : "host2 return count",
                    64'((page == 1) ? hostCnt1 : hostCnt2), 64'(target));
        @(posedge trn_clk);
        #1;
        if (page == 1) hw1 = 1'b0;
        else           hw2 = 1'b0;
    endtask

    // Scoreboard monitor: compare accepted requests and returned pages against expectations.
    always @(negedge trn_clk) begin
        chunk_t e;
        int     page;
        if (reset_n && req_valid && req_ready) begin
            acceptCount++;
            if (expQ.size() == 0) begin
                checkOutput("spurious request queue depth", 64'(expQ.size()), 64'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("req_addr", req_addr, e.addr);
                checkOutput("req_len_qw", 64'(req_len_qw), 64'(e.len));
            end
        end
        if (host1 || host2) begin
            page = (host1 && host2) ? 3 : (host1 ? 1 : 2);
            if (host1) begin hostCnt1++; hostCyc1 = cyc; end
            if (host2) begin hostCnt2++; hostCyc2 = cyc; end
            if (expPageQ.size() == 0) begin
                checkOutput("spurious page return queue depth", 64'(expPageQ.size()), 64'd1);
            end else begin
                checkOutput("returned page", 64'(page), 64'(expPageQ.pop_front()));
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        hw1        = 1'b0;
        hw2        = 1'b0;
        addr1      = 64'd0;
        addr2      = 64'd0;
        qw1        = 32'd0;
        qw2        = 32'd0;
        req_ready  = 1'b0;
        chunk_done = 1'b0;
        repeat (3) @(posedge trn_clk);
        @(negedge trn_clk);
        checkOutput("reset req_valid", 64'(req_valid), 64'd0);
        checkOutput("reset req_addr", req_addr, 64'd0);
        checkOutput("reset req_len_qw", 64'(req_len_qw), 64'd0);
        checkOutput("reset host pulses", 64'({host1, host2}), 64'd0);
        checkOutput("reset protocol_err", 64'(protocol_err), 64'd0);
        @(posedge trn_clk);
        #1;
        reset_n   = 1'b1;
        req_ready = 1'b1;

        // Page 1: two full-size chunks, then release two cycles after the last completion.
        $display("[TB] page 1, 128 qwords");
        applyStimulus(1, 64'h1_0000_0000, 32'd128);
        @(negedge trn_clk);
        @(negedge trn_clk);
        checkOutput("req_valid during LOAD", 64'(req_valid), 64'd0);
        @(negedge trn_clk);
        checkOutput("first req_valid", 64'(req_valid), 64'd1);
        waitAccepts(2, "page1 accepts");
        pulseDone();
        pulseDone();
        waitHost(1, 1);
        checkOutput("release latency after last done", 64'(hostCyc1 - doneCyc), 64'd2);

        // Page 2: a page starting 64 bytes below a 4 KB boundary.
        $display("[TB] page 2, boundary split");
        applyStimulus(2, 64'h0FC0, 32'd32);
        waitAccepts(4, "boundary page accepts");
        pulseDone();
        pulseDone();
        waitHost(2, 1);

        // Page 1 then a zero-length page 2 that must not issue anything.
        $display("[TB] page 1 then zero-length page 2");
        applyStimulus(1, 64'h3000, 32'd8);
        applyStimulus(2, 64'h5555_0000, 32'd0);
        waitAccepts(5, "small page accepts");
        pulseDone();
        waitHost(1, 2);
        waitHost(2, 2);
        checkOutput("zero page release gap", 64'(hostCyc2 - hostCyc1), 64'd3);

        // Credit limit: only MAX_OUT chunks in flight until completions arrive.
        $display("[TB] credit limit");
        applyStimulus(1, 64'h4_0000, 32'd512);
        repeat (12) @(negedge trn_clk);
        #2;
        checkOutput("credit-limited accepts", 64'(acceptCount - 5), 64'd2);
        checkOutput("req_valid without credit", 64'(req_valid), 64'd0);
        pulseDone();
        repeat (5) @(negedge trn_clk);
        #2;
        checkOutput("accepts after one done", 64'(acceptCount - 5), 64'd3);
        repeat (7) begin
            pulseDone();
            @(posedge trn_clk);
        end
        waitAccepts(13, "credit page accepts");
        waitHost(1, 3);

        // Stray completion while idle sets the sticky error.
        $display("[TB] stray completion");
        pulseDone();
        @(negedge trn_clk);
        checkOutput("protocol_err after stray done", 64'(protocol_err), 64'd1);

        // Page 2 with unaligned address bits, scheduling unaffected by the error.
        applyStimulus(2, 64'h7, 32'd3);
        waitAccepts(14, "unaligned page accepts");
        pulseDone();
        waitHost(2, 3);
        checkOutput("protocol_err sticky", 64'(protocol_err), 64'd1);

        // Only page 2 ready while page 1 is selected: nothing may be issued.
        $display("[TB] ping-pong order and mid-page reset");
        @(posedge trn_clk);
        #1;
        req_ready = 1'b0;
        hw2       = 1'b1;
        addr2     = 64'hA000;
        qw2       = 32'd4;
        repeat (6) @(negedge trn_clk);
        #2;
        checkOutput("page2 waits for page1", 64'(acceptCount), 64'd14);
        checkOutput("req_valid while page1 absent", 64'(req_valid), 64'd0);
        applyStimulus(1, 64'h8000, 32'd512);
        repeat (4) @(negedge trn_clk);
        checkOutput("req_valid held", 64'(req_valid), 64'd1);
        checkOutput("held req_addr", req_addr, 64'h8000);
        checkOutput("held req_len_qw", 64'(req_len_qw), 64'd64);
        @(posedge trn_clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset req_valid", 64'(req_valid), 64'd0);
        expQ.delete();
        expPageQ.delete();
        hw1 = 1'b0;
        @(negedge trn_clk);
        checkOutput("reset mid-page req_addr", req_addr, 64'd0);
        checkOutput("reset clears protocol_err", 64'(protocol_err), 64'd0);
        checkOutput("reset mid-page host pulses", 64'({host1, host2}), 64'd0);
        @(posedge trn_clk);
        #1;
        reset_n   = 1'b1;
        req_ready = 1'b1;
        repeat (6) @(negedge trn_clk);
        #2;
        checkOutput("no service before page1 after reset", 64'(acceptCount), 64'd14);
        applyStimulus(1, 64'h9000, 32'd16);
        applyStimulus(2, 64'hA000, 32'd4);
        waitAccepts(15, "post-reset page1 accepts");
        pulseDone();
        waitHost(1, 4);
        waitAccepts(16, "post-reset page2 accepts");
        pulseDone();
        waitHost(2, 4);
        checkOutput("scoreboard drained", 64'(expQ.size() + expPageQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
